// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler and its arbiter.
package uart_tx_scheduler_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } sched_state_e;

    // Modular add for requester indices; both operands must already be below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted valid at or after the pointer, wrapping past NUM_REQ-1.
module uart_tx_scheduler_rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic [NUM_REQ-1:0]         onehot
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'(wrap_add(int'(ptr), i, NUM_REQ));
            if (!any && valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte streams with round-robin, packet-locked grants.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [NUM_REQ-1:0]             grant_onehot,
    output logic                           busy,
    output logic                           timeout_pulse
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [7:0]        BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    logic                   arb_any;
    logic [IDX_W-1:0]       arb_idx;
    logic [NUM_REQ-1:0]     arb_onehot;

    logic                   locked;
    logic                   own_valid;
    logic                   own_last;
    logic [UART_BYTE_W-1:0] own_data;
    logic                   handshake;
    logic                   rel_last;
    logic                   rel_burst;
    logic                   rel_timeout;

    uart_tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .any    (arb_any),
        .idx    (arb_idx),
        .onehot (arb_onehot)
    );

    assign locked    = (state_q == StLocked);
    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_data  = req_data[UART_BYTE_W*owner_q +: UART_BYTE_W];

    assign handshake = locked && own_valid && tx_ready;
    assign rel_last  = handshake && own_last;
    assign rel_burst = handshake && (byte_cnt_q == BURST_LAST);
    // Timeout needs valid low, so it can never coincide with a handshake release.
    assign rel_timeout = locked && !own_valid && (idle_cnt_q == IDLE_LAST);

    assign busy          = locked;
    assign grant_onehot  = grant_q;
    assign timeout_pulse = rel_timeout;

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (locked) begin
            tx_valid           = own_valid;
            tx_data            = own_data;
            req_ready[owner_q] = tx_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    state_d = StLocked;
                    owner_d = arb_idx;
                    grant_d = arb_onehot;
                end
            end
            StLocked: begin
                if (handshake) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
                if (own_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
                if (rel_last || rel_burst || rel_timeout) begin
                    state_d    = StIdle;
                    grant_d    = '0;
                    ptr_d      = IDX_W'(wrap_add(int'(owner_q), 1, NUM_REQ));
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: packet-level round-robin model plus directed corner cases.
module tb_uart_tx_scheduler;

    localparam int N  = 2;
    localparam int MB = 4;
    localparam int TO = 16;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   grant_onehot;
    logic           busy;
    logic           timeout_pulse;

    uart_tx_scheduler #(
        .NUM_REQ      (N),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant_onehot  (grant_onehot),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int to_count = 0;
    int model_ptr = 0;
    bit gap_en = 1'b0;
    bit hold_ready = 1'b0;

    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic [8:0] m0[$];
    logic [8:0] m1[$];
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int r, input logic [7:0] d, input bit last);
        if (r == 0) begin
            src0.push_back({last, d});
            m0.push_back({last, d});
        end else begin
            src1.push_back({last, d});
            m1.push_back({last, d});
        end
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    // Packet-level reference: owners rotate over non-empty queues, each grant ends on
    // a last byte, after MB bytes, or when the owner runs dry (which the DUT ends by timeout).
    task automatic model_run();
        while (m0.size() + m1.size() > 0) begin
            int g;
            int n;
            bit done;
            logic [8:0] e;
            g = model_ptr;
            if ((g == 0 && m0.size() == 0) || (g == 1 && m1.size() == 0)) g = 1 - g;
            n = 0;
            done = 1'b0;
            while (!done) begin
                if (g == 0) e = m0.pop_front();
                else        e = m1.pop_front();
                push_exp((g == 0) ? 2'b01 : 2'b10, e[7:0]);
                n++;
                done = e[8] || (n == MB) || ((g == 0) ? (m0.size() == 0) : (m1.size() == 0));
            end
            model_ptr = (g + 1) % N;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            step();
            c++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] g, input int budget);
        int c = 0;
        while (grant_onehot !== g && c < budget) begin
            step();
            c++;
        end
        check(name, 32'(grant_onehot), 32'(g));
    endtask

    // Requesters plus transmitter: inputs change only just after the rising edge.
    initial begin : driver
        logic [N-1:0] acc;
        logic [8:0]   f0;
        logic [8:0]   f1;
        int           gap[N];
        for (int i = 0; i < N; i++) gap[i] = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (acc[0] && src0.size() > 0) void'(src0.pop_front());
            if (acc[1] && src1.size() > 0) void'(src1.pop_front());
            for (int i = 0; i < N; i++) begin
                if (!grant_onehot[i]) gap[i] = 0;
                else if (gap[i] > 0) gap[i]--;
                else if (acc[i] && gap_en && $urandom_range(0, 3) == 0)
                    gap[i] = int'($urandom_range(1, 5));
            end
            f0 = (src0.size() > 0) ? src0[0] : 9'h000;
            f1 = (src1.size() > 0) ? src1[0] : 9'h000;
            req_valid[0]  = (src0.size() > 0) && (gap[0] == 0);
            req_valid[1]  = (src1.size() > 0) && (gap[1] == 0);
            req_data[7:0] = f0[7:0];
            req_data[15:8] = f1[7:0];
            req_last[0]   = f0[8];
            req_last[1]   = f1[8];
            tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (timeout_pulse === 1'b1) to_count++;
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected_byte", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_owner_and_data", 32'({grant_onehot, tx_data}), 32'(e));
                        check("req_ready_owner", 32'(req_ready), 32'(e[9:8]));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int to_before;
        int k;
        int c;
        int bad;
        rst_n = 1'b0;

        // Reset while both requesters offer, then contention 61,62 vs 41.
        load(0, 8'h61, 1'b0);
        load(0, 8'h62, 1'b1);
        load(1, 8'h41, 1'b1);
        model_run();
        repeat (3) step();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_onehot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
        rst_n = 1'b1;
        check("grant_before_edge", 32'(grant_onehot), 32'd0);
        step();
        check("grant_after_release", 32'(grant_onehot), 32'b01);
        check("busy_after_release", 32'(busy), 32'd1);
        wait_drain("drain_contention", 200);
        repeat (2) step();

        // Pointer wrapped from 1 back to 0: req0 wins the next tie.
        load(0, 8'h71, 1'b1);
        load(1, 8'h42, 1'b1);
        model_run();
        wait_drain("drain_rr_wrap", 200);
        repeat (2) step();

        // Burst cap: req1 streams six bytes without last while req0 waits.
        to_before = to_count;
        for (int i = 0; i < 4; i++) push_exp(2'b10, 8'(8'hA0 + i));
        push_exp(2'b01, 8'hB0);
        push_exp(2'b01, 8'hB1);
        push_exp(2'b10, 8'hA4);
        push_exp(2'b10, 8'hA5);
        for (int i = 0; i < 6; i++) load(1, 8'(8'hA0 + i), 1'b0);
        wait_grant("burst_grant_req1", 2'b10, 50);
        load(0, 8'hB0, 1'b0);
        load(0, 8'hB1, 1'b1);
        m0.delete();
        m1.delete();
        wait_drain("drain_burst", 400);
        repeat (TO + 4) step();
        check("burst_tail_timeout_count", 32'(to_count - to_before), 32'd1);
        model_ptr = 0;

        // Idle timeout: req0 sends 55 without last and goes quiet.
        to_before = to_count;
        push_exp(2'b01, 8'h55);
        push_exp(2'b10, 8'h43);
        load(0, 8'h55, 1'b0);
        m0.delete();
        wait_grant("timeout_grant_req0", 2'b01, 50);
        load(1, 8'h43, 1'b1);
        m1.delete();
        c = 0;
        while (exp_q.size() != 1 && c < 200) begin
            step();
            c++;
        end
        check("timeout_first_byte", 32'(exp_q.size()), 32'd1);
        k = 0;
        do begin
            step();
            k++;
        end while (timeout_pulse !== 1'b1 && k < TO + 8);
        check("timeout_pulse_cycle", 32'(k), 32'(TO));
        step();
        check("busy_after_timeout", 32'(busy), 32'd0);
        check("pulse_one_cycle", 32'(timeout_pulse), 32'd0);
        step();
        check("grant_req1_after_timeout", 32'(grant_onehot), 32'b10);
        wait_drain("drain_timeout", 200);
        check("timeout_count", 32'(to_count - to_before), 32'd1);
        model_ptr = 0;

        // Backpressure: a stalled owner with valid high never times out.
        hold_ready = 1'b1;
        repeat (2) step();
        to_before = to_count;
        push_exp(2'b01, 8'h63);
        load(0, 8'h63, 1'b1);
        m0.delete();
        wait_grant("bp_grant_req0", 2'b01, 50);
        bad = 0;
        repeat (5000) begin
            step();
            if (!(tx_valid === 1'b1 && tx_data === 8'h63 && timeout_pulse === 1'b0)) bad++;
        end
        check("bp_offer_stable", 32'(bad), 32'd0);
        check("bp_no_timeout", 32'(to_count - to_before), 32'd0);
        check("bp_byte_pending", 32'(exp_q.size()), 32'd1);
        hold_ready = 1'b0;
        wait_drain("drain_bp", 100);
        model_ptr = 1;
        repeat (2) step();

        // Reset in the middle of a ten-byte packet, after two bytes have gone.
        push_exp(2'b01, 8'hC0);
        push_exp(2'b01, 8'hC1);
        for (int i = 0; i < 10; i++) load(0, 8'(8'hC0 + i), (i == 9));
        m0.delete();
        wait_drain("mid_first_two", 200);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        src0.delete();
        src1.delete();
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_grant", 32'(grant_onehot), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
        model_ptr = 0;
        repeat (3) step();
        rst_n = 1'b1;
        load(0, 8'hD0, 1'b0);
        load(0, 8'hD1, 1'b1);
        load(1, 8'hE0, 1'b1);
        model_run();
        wait_drain("drain_after_reset", 200);
        repeat (2) step();

        // Randomized packets with owner gaps and a ready-toggling transmitter.
        gap_en = 1'b1;
        to_before = to_count;
        for (int round = 0; round < 10; round++) begin
            for (int r = 0; r < N; r++) begin
                int npk;
                npk = int'($urandom_range(0, 3));
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = int'($urandom_range(1, 7));
                    for (int b = 0; b < len; b++) load(r, 8'($urandom), (b == len - 1));
                end
            end
            model_run();
            wait_drain("drain_random", 3000);
            repeat (2) step();
        end
        check("random_no_timeout", 32'(to_count - to_before), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
